// File: rtl/axi_rw_arbiter.sv
// Merges icache reads and dcache refills/writebacks onto one AXI4 master port.
// Optional macro AXI_RESP_CHECK_EN enables the sticky bus_err response flag.
module axi_rw_arbiter #(
    parameter bit D_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_arvalid,
    output logic        i_arready,
    input  logic [31:0] i_araddr,
    output logic        i_rvalid,
    output logic        i_rlast,
    input  logic        i_rready,
    output logic [31:0] i_rdata,
    input  logic        d_arvalid,
    output logic        d_arready,
    input  logic [31:0] d_araddr,
    output logic        d_rvalid,
    output logic        d_rlast,
    input  logic        d_rready,
    output logic [31:0] d_rdata,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_awaddr,
    input  logic        d_wvalid,
    input  logic        d_wlast,
    output logic        d_wready,
    input  logic [31:0] d_wdata,
    output logic        d_bvalid,
    input  logic        d_bready,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awid,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_wvalid,
    output logic        m_wlast,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    output logic        bus_err
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wstate_t;

    rstate_t     rstate, rstate_nxt;
    wstate_t     wstate, wstate_nxt;
    logic [31:0] araddr_q, awaddr_q;
    logic        arid_q, prio_d;
    logic        hazard, d_req, grant_i, grant_d;

    assign m_arlen   = 8'd3;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_awlen   = 8'd3;
    assign m_awsize  = 3'b010;
    assign m_awburst = 2'b01;
    assign m_awid    = 4'd1;
    assign m_wstrb   = 4'hF;

    // A refill must not overtake a pending writeback of the same line.
    assign hazard = (wstate != W_IDLE) && (d_araddr[31:4] == awaddr_q[31:4]);
    assign d_req  = d_arvalid && !hazard;

    always_comb begin
        rstate_nxt = rstate;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (d_req && (!i_arvalid || prio_d)) grant_d = 1'b1;
                else if (i_arvalid)                  grant_i = 1'b1;
                if (grant_d || grant_i) rstate_nxt = R_AR;
            end
            R_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                if (arid_q) begin
                    d_rvalid = m_rvalid;
                    m_rready = d_rready;
                end else begin
                    i_rvalid = m_rvalid;
                    m_rready = i_rready;
                end
                if (m_rvalid && m_rready && m_rlast) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign i_arready = grant_i;
    assign d_arready = grant_d;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign i_rlast   = m_rlast && (rstate == R_DATA) && !arid_q;
    assign d_rlast   = m_rlast && (rstate == R_DATA) && arid_q;
    assign m_araddr  = araddr_q;
    assign m_arid    = {3'b000, arid_q};

    // prio_d records which side wins the next tie: the last winner loses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate   <= R_IDLE;
            araddr_q <= '0;
            arid_q   <= 1'b0;
            prio_d   <= D_FIRST;
        end else begin
            rstate <= rstate_nxt;
            if (grant_d) begin
                araddr_q <= d_araddr;
                arid_q   <= 1'b1;
                prio_d   <= 1'b0;
            end else if (grant_i) begin
                araddr_q <= i_araddr;
                arid_q   <= 1'b0;
                prio_d   <= 1'b1;
            end
        end
    end

    always_comb begin
        wstate_nxt = wstate;
        d_awready  = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        d_wready   = 1'b0;
        m_bready   = 1'b0;
        d_bvalid   = 1'b0;
        case (wstate)
            W_IDLE: begin
                d_awready = d_awvalid;
                if (d_awvalid) wstate_nxt = W_AW;
            end
            W_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                m_wvalid = d_wvalid;
                d_wready = m_wready;
                if (d_wvalid && m_wready && d_wlast) wstate_nxt = W_B;
            end
            W_B: begin
                m_bready = d_bready;
                d_bvalid = m_bvalid;
                if (m_bvalid && d_bready) wstate_nxt = W_IDLE;
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    assign m_awaddr = awaddr_q;
    assign m_wdata  = d_wdata;
    assign m_wlast  = d_wlast && (wstate == W_DATA);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate   <= W_IDLE;
            awaddr_q <= '0;
        end else begin
            wstate <= wstate_nxt;
            if (wstate == W_IDLE && d_awvalid) awaddr_q <= d_awaddr;
        end
    end

`ifdef AXI_RESP_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_err <= 1'b0;
        end else if ((m_rvalid && m_rready && (m_rresp != 2'b00)) ||
                     (m_bvalid && m_bready && (m_bresp != 2'b00))) begin
            bus_err <= 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_rresp, m_bresp};
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed bench for axi_rw_arbiter: reads, arbitration, writeback stalls,
// same-line hazard, AR back-pressure, response errors and mid-burst reset.
module tb_axi_rw_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
    logic [31:0] i_araddr, i_rdata;
    logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
    logic [31:0] d_araddr, d_rdata;
    logic        d_awvalid, d_awready, d_wvalid, d_wlast, d_wready, d_bvalid, d_bready;
    logic [31:0] d_awaddr, d_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_awid, m_wstrb;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst, m_bresp;
    logic        bus_err;

`ifdef AXI_RESP_CHECK_EN
    localparam bit RESP_EN = 1'b1;
`else
    localparam bit RESP_EN = 1'b0;
`endif

    axi_rw_arbiter #(.D_FIRST(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr),
        .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready), .i_rdata(i_rdata),
        .d_arvalid(d_arvalid), .d_arready(d_arready), .d_araddr(d_araddr),
        .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready), .d_rdata(d_rdata),
        .d_awvalid(d_awvalid), .d_awready(d_awready), .d_awaddr(d_awaddr),
        .d_wvalid(d_wvalid), .d_wlast(d_wlast), .d_wready(d_wready), .d_wdata(d_wdata),
        .d_bvalid(d_bvalid), .d_bready(d_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .bus_err(bus_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Waits for the AR request, holds m_arready low for 'stall' cycles, then accepts.
    task automatic ar_phase(input logic id, input logic [31:0] addr, input int stall);
        int waited = 0;
        smp();
        while (!m_arvalid && waited < 10) begin
            step();
            smp();
            waited++;
        end
        chk("ar_latency", waited, 0);
        for (int k = 0; k < stall; k++) begin
            chk("ar_hold_valid", m_arvalid, 1);
            chk("ar_hold_addr", m_araddr, addr);
            step();
            smp();
        end
        chk("arvalid", m_arvalid, 1);
        chk("araddr", m_araddr, addr);
        chk("arid", m_arid, {28'd0, 3'b000, id});
        chk("arlen", m_arlen, 3);
        chk("arsize", m_arsize, 3'b010);
        chk("arburst", m_arburst, 2'b01);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
    endtask

    // Slave returns four beats d0..d0+3; err_beat (or -1) carries SLVERR.
    task automatic r_phase(input logic id, input logic [31:0] d0, input int err_beat);
        if (id) d_rready = 1'b1; else i_rready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = d0 + b;
            m_rlast  = (b == 3);
            m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            smp();
            chk("rvalid_granted", id ? d_rvalid : i_rvalid, 1);
            chk("rvalid_other", id ? i_rvalid : d_rvalid, 0);
            chk("rdata", id ? d_rdata : i_rdata, d0 + b);
            chk("rlast", id ? d_rlast : i_rlast, (b == 3));
            chk("m_rready", m_rready, 1);
            chk("no_igrant_busy", i_arready, 0);
            chk("no_dgrant_busy", d_arready, 0);
            chk("bus_err_beat", bus_err, RESP_EN && err_beat >= 0 && b > err_beat);
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'b00;
        i_rready = 1'b0;
        d_rready = 1'b0;
    endtask

    task automatic w_start(input logic [31:0] addr);
        d_awvalid = 1'b1;
        d_awaddr  = addr;
        smp();
        chk("awready", d_awready, 1);
        step();
        d_awvalid = 1'b0;
    endtask

    // Beats 0x11,0x22,0x33,0x44; m_wready low for stall_n cycles on stall_beat.
    task automatic w_finish(input logic [31:0] addr, input int stall_beat, input int stall_n);
        smp();
        chk("awvalid", m_awvalid, 1);
        chk("awaddr", m_awaddr, addr);
        chk("awid", m_awid, 1);
        chk("awlen", m_awlen, 3);
        chk("awsize", m_awsize, 3'b010);
        chk("awburst", m_awburst, 2'b01);
        chk("haz_aw", d_arready, 0);
        m_awready = 1'b1;
        step();
        m_awready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            d_wvalid = 1'b1;
            d_wdata  = 32'h11 * (b + 1);
            d_wlast  = (b == 3);
            if (b == stall_beat) begin
                m_wready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    smp();
                    chk("wvalid_stall", m_wvalid, 1);
                    chk("wdata_stall", m_wdata, 32'h11 * (b + 1));
                    chk("wready_stall", d_wready, 0);
                    chk("haz_wstall", d_arready, 0);
                    step();
                end
            end
            m_wready = 1'b1;
            smp();
            chk("wvalid", m_wvalid, 1);
            chk("wdata", m_wdata, 32'h11 * (b + 1));
            chk("wlast", m_wlast, (b == 3));
            chk("wstrb", m_wstrb, 4'hF);
            chk("wready", d_wready, 1);
            chk("haz_w", d_arready, 0);
            step();
        end
        d_wvalid = 1'b0;
        d_wlast  = 1'b0;
        m_wready = 1'b0;
        d_bready = 1'b1;
        smp();
        chk("bvalid_low", d_bvalid, 0);
        chk("bready", m_bready, 1);
        chk("haz_b", d_arready, 0);
        step();
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        smp();
        chk("bvalid_high", d_bvalid, 1);
        chk("haz_bhs", d_arready, 0);
        step();
        m_bvalid = 1'b0;
        d_bready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        {i_arvalid, i_rready, d_arvalid, d_rready, d_awvalid, d_wvalid, d_wlast, d_bready} = '0;
        {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = '0;
        i_araddr = '0; d_araddr = '0; d_awaddr = '0; d_wdata = '0;
        m_rdata = '0; m_rresp = '0; m_bresp = '0;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_arlen", m_arlen, 3);
        chk("rst_wstrb", m_wstrb, 4'hF);
        rstn = 1'b1;
        step();

        // icache-only read
        i_arvalid = 1'b1;
        i_araddr  = 32'h1C00_0040;
        smp();
        chk("t1_igrant", i_arready, 1);
        chk("t1_dgrant", d_arready, 0);
        step();
        i_arvalid = 1'b0;
        ar_phase(1'b0, 32'h1C00_0040, 0);
        r_phase(1'b0, 32'hA0, -1);
        smp();
        chk("t1_idle_ir", i_rvalid, 0);
        chk("t1_idle_dr", d_rvalid, 0);
        step();

        // simultaneous requests: dcache first, icache right after its rlast
        i_arvalid = 1'b1;
        i_araddr  = 32'h2000_0100;
        d_arvalid = 1'b1;
        d_araddr  = 32'h3000_0200;
        smp();
        chk("t2_dgrant", d_arready, 1);
        chk("t2_ilose", i_arready, 0);
        step();
        d_arvalid = 1'b0;
        ar_phase(1'b1, 32'h3000_0200, 0);
        r_phase(1'b1, 32'hB0, -1);
        smp();
        chk("t2_igrant_after", i_arready, 1);
        step();
        i_arvalid = 1'b0;
        ar_phase(1'b0, 32'h2000_0100, 0);
        r_phase(1'b0, 32'hC0, -1);

        // writeback with beat-2 stall of three cycles
        w_start(32'h0000_1230);
        w_finish(32'h0000_1230, 1, 3);

        // same-line hazard: refill held off, icache served meanwhile
        w_start(32'h0000_1230);
        d_arvalid = 1'b1;
        d_araddr  = 32'h0000_123C;
        i_arvalid = 1'b1;
        i_araddr  = 32'h4000_0000;
        smp();
        chk("t4_dblocked", d_arready, 0);
        chk("t4_igrant", i_arready, 1);
        step();
        i_arvalid = 1'b0;
        ar_phase(1'b0, 32'h4000_0000, 0);
        r_phase(1'b0, 32'hD0, -1);
        smp();
        chk("t4_still_blocked", d_arready, 0);
        step();
        w_finish(32'h0000_1230, -1, 0);
        smp();
        chk("t4_dgrant_after_b", d_arready, 1);
        step();
        d_arvalid = 1'b0;
        ar_phase(1'b1, 32'h0000_123C, 0);
        r_phase(1'b1, 32'hE0, -1);

        // AR back-pressure for five cycles, SLVERR on beat 2
        d_arvalid = 1'b1;
        d_araddr  = 32'h5555_0000;
        smp();
        chk("t5_dgrant", d_arready, 1);
        step();
        d_arvalid = 1'b0;
        ar_phase(1'b1, 32'h5555_0000, 5);
        r_phase(1'b1, 32'hF0, 1);
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("t5_bus_err_sticky", bus_err, RESP_EN);
            step();
        end

        // reset in the middle of a read burst
        i_arvalid = 1'b1;
        i_araddr  = 32'h6000_0000;
        smp();
        chk("t6_igrant", i_arready, 1);
        step();
        i_arvalid = 1'b0;
        ar_phase(1'b0, 32'h6000_0000, 0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h77;
        i_rready = 1'b1;
        smp();
        chk("t6_rvalid_pre", i_rvalid, 1);
        rstn = 1'b0;
        #1;
        chk("t6_rvalid_rst", i_rvalid, 0);
        chk("t6_rready_rst", m_rready, 0);
        chk("t6_araddr_rst", m_araddr, 0);
        chk("t6_bus_err_rst", bus_err, 0);
        step();
        m_rvalid = 1'b0;
        i_rready = 1'b0;
        smp();
        rstn = 1'b1;
        step();
        i_arvalid = 1'b1;
        i_araddr  = 32'h7000_0080;
        smp();
        chk("t6_igrant_post", i_arready, 1);
        step();
        i_arvalid = 1'b0;
        ar_phase(1'b0, 32'h7000_0080, 0);
        r_phase(1'b0, 32'h80, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
